preif_pc_gen: RTL and testbench
===============================

# preif_pc_gen

Parametrised pre-fetch PC generator for the PRE_IF stage. It holds the fetch PC and advances it by one aligned fetch block per cycle. It selects among prioritised redirect sources (exception, branch resolve, branch predictor) and buffers a redirect that arrives during a stall, so no redirect is lost. It drives the I-cache request address and the per-slot valid mask for multi-instruction fetch.

## Interface
- ADDR_W, 32, PC width in bits.
- FETCH_N, 2, instructions per fetch block; power of two, 1..8.
- NUM_REDIR, 3, number of redirect sources; index 0 is highest priority.
- RESET_PC, 32'hBFC0_0000, PC value loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- stall_i  in  1  when high, the PC holds; when low, the PC updates each edge.
- redir_valid_i  in  NUM_REDIR  one-hot-or-more redirect requests.
- redir_target_i  in  NUM_REDIR×ADDR_W  redirect target per source.
- pc_o  out  ADDR_W  current fetch PC (registered).
- pc_valid_o  out  1  PC is a live fetch address.
- fetch_mask_o  out  FETCH_N  slot i valid within the aligned block.
- redir_pending_o  out  1  a buffered redirect is waiting for stall release.
- addr_err_o  out  1  pc_o is misaligned (see Configuration).

## Operation
- BLK_BYTES = 4·FETCH_N.
- Sequential next PC = (pc_o & ~(BLK_BYTES-1)) + BLK_BYTES, modulo 2^ADDR_W. Wrap from the top block to 0 is silent.
- Arbitration: the lowest asserted index among redir_valid_i wins and gives (new_idx, new_tgt).
- The pending buffer holds (pend_idx, pend_tgt) and is valid only in state PEND.
- States:
  - RUN, stall_i=0: a new redirect loads new_tgt; otherwise pc_o loads the sequential next PC. State stays RUN.
  - RUN, stall_i=1, redirect present: latch (new_idx, new_tgt) and go to PEND. pc_o holds.
  - RUN, stall_i=1, no redirect: hold.
  - PEND, stall_i=1: a new redirect with new_idx ≤ pend_idx overwrites the buffer; otherwise the buffer is kept. pc_o holds.
  - PEND, stall_i=0: if a new redirect has new_idx ≤ pend_idx, load new_tgt; otherwise load pend_tgt. Go to RUN.
- fetch_mask_o[i] = (i ≥ pc_o[log2(FETCH_N)+1:2]). This is combinational from pc_o. With FETCH_N=1 it is constantly 1.
- redir_pending_o = (state == PEND).
- pc_valid_o is 0 in the cycle after reset is applied. It is 1 from the first edge with rst=0 onward.

## Timing
- Reset values: pc_o=RESET_PC, pc_valid_o=0, redir_pending_o=0, addr_err_o=0, state RUN, buffer cleared.
- fetch_mask_o after reset is derived from RESET_PC.
- Redirect latency: a redirect sampled at edge N with stall_i=0 appears on pc_o after edge N.
- A buffered redirect appears on pc_o after the first edge with stall_i=0.
- Simultaneous events:
  - rst beats everything.
  - A redirect beats sequential increment.
  - Equal index: the new request beats the buffered one.
- Reset mid-stall with a pending redirect discards the buffer.
- A redirect on the same edge stall releases obeys the PEND, stall_i=0 rule.

## Configuration
- Macro `PC_ALIGN_CHECK_EN`, defined:
  - Targets load unmodified.
  - addr_err_o is registered with pc_o and equals (target[1:0] != 2'b00) for the loaded value.
  - The sequential increment clears addr_err_o, because the block base is aligned.
- Macro undefined:
  - target[1:0] is forced to 2'b00 on load.
  - addr_err_o is tied to 0.

## Structure
- Package pc_pkg holds:
  - state enum {RUN, PEND}.
  - redirect index constants REDIR_EXC=0, REDIR_BR=1, REDIR_BPU=2.
  - the default RESET_PC.
- Sub-module pc_redirect_arb: a combinational fixed-priority select producing (any, idx, tgt). It is instantiated once.

## Test plan
- Reset, then 4 free-running cycles with FETCH_N=2: pc_o = BFC00000, BFC00008, BFC00010, BFC00018; mask 2'b11 throughout.
- With stall_i=0, redirects 1 (tgt 80000004) and 2 (tgt 80001000) asserted together: next pc_o=80000004 and fetch_mask_o=2'b10; the following cycle pc_o=80000008.
- With stall_i=1:
  - redirect 2 (tgt 100), then 1 cycle later redirect 0 (tgt BFC00380), then stall held 3 cycles.
  - redir_pending_o=1 throughout.
  - After release, pc_o=BFC00380.
- Stall with pending idx 0, then release while redirect 2 is asserted: pc_o takes the buffered target and redirect 2 is ignored.
- Pending redirect present and rst asserted during the stall: after reset pc_o=RESET_PC and redir_pending_o=0.
- With `PC_ALIGN_CHECK_EN` defined:
  - Redirect to 80000006 gives pc_o=80000006 and addr_err_o=1.
  - The next sequential cycle gives pc_o=80000008 and addr_err_o=0.
  - Macro undefined: the same redirect gives pc_o=80000004 and addr_err_o=0.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the PRE_IF fetch PC generator.
package pc_pkg;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_e;

  localparam int unsigned REDIR_EXC = 0;
  localparam int unsigned REDIR_BR  = 1;
  localparam int unsigned REDIR_BPU = 2;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'hBFC0_0000;

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect select: lowest asserted index wins.
module pc_redirect_arb #(
  parameter int unsigned NUM_REDIR = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned IDX_W     = 2
) (
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
  output logic                        any_o,
  output logic [IDX_W-1:0]            idx_o,
  output logic [ADDR_W-1:0]           tgt_o
);

  always_comb begin
    any_o = |redir_valid_i;
    idx_o = '0;
    tgt_o = '0;
    // Walk from lowest priority up so the lowest set index is written last.
    for (int i = NUM_REDIR - 1; i >= 0; i--) begin
      if (redir_valid_i[i]) begin
        idx_o = IDX_W'(i);
        tgt_o = redir_target_i[i*ADDR_W +: ADDR_W];
      end
    end
  end

endmodule

// File: rtl/preif_pc_gen.sv
// PRE_IF fetch PC generator with prioritised, stall-buffered redirects.
// Optional macro PC_ALIGN_CHECK_EN: keep target low bits and flag misalignment on addr_err_o.
module preif_pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W    = 32,
  parameter int unsigned       FETCH_N   = 2,
  parameter int unsigned       NUM_REDIR = 3,
  parameter logic [ADDR_W-1:0] RESET_PC  = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall_i,
  input  logic [NUM_REDIR-1:0]        redir_valid_i,
  input  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i,
  output logic [ADDR_W-1:0]           pc_o,
  output logic                        pc_valid_o,
  output logic [FETCH_N-1:0]          fetch_mask_o,
  output logic                        redir_pending_o,
  output logic                        addr_err_o
);

  localparam int unsigned IDX_W     = (NUM_REDIR > 1) ? $clog2(NUM_REDIR) : 1;
  localparam int unsigned OFF_W     = (FETCH_N > 1) ? $clog2(FETCH_N) : 1;
  localparam int unsigned BLK_BYTES = 4 * FETCH_N;
  localparam logic [ADDR_W-1:0] BLK_MASK = ADDR_W'(BLK_BYTES - 1);

  pc_state_e         state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              pc_valid_q;
  logic [IDX_W-1:0]  pend_idx_q, pend_idx_d;
  logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

  logic              arb_any;
  logic [IDX_W-1:0]  arb_idx;
  logic [ADDR_W-1:0] arb_tgt;
  logic [ADDR_W-1:0] seq_pc, load_tgt;
  logic              do_load, do_seq, take_new;

  pc_redirect_arb #(
    .NUM_REDIR(NUM_REDIR),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_arb (
    .redir_valid_i (redir_valid_i),
    .redir_target_i(redir_target_i),
    .any_o         (arb_any),
    .idx_o         (arb_idx),
    .tgt_o         (arb_tgt)
  );

  assign seq_pc   = (pc_q & ~BLK_MASK) + ADDR_W'(BLK_BYTES);
  // Equal index favours the fresh request over the buffered one.
  assign take_new = arb_any && (arb_idx <= pend_idx_q);

  always_comb begin
    state_d    = state_q;
    pend_idx_d = pend_idx_q;
    pend_tgt_d = pend_tgt_q;
    do_load    = 1'b0;
    do_seq     = 1'b0;
    load_tgt   = arb_tgt;
    unique case (state_q)
      RUN: begin
        if (!stall_i) begin
          do_load = arb_any;
          do_seq  = !arb_any;
        end else if (arb_any) begin
          pend_idx_d = arb_idx;
          pend_tgt_d = arb_tgt;
          state_d    = PEND;
        end
      end
      PEND: begin
        if (stall_i) begin
          if (take_new) begin
            pend_idx_d = arb_idx;
            pend_tgt_d = arb_tgt;
          end
        end else begin
          do_load  = 1'b1;
          load_tgt = take_new ? arb_tgt : pend_tgt_q;
          state_d  = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef PC_ALIGN_CHECK_EN
  logic addr_err_q, addr_err_d;

  always_comb begin
    pc_d       = pc_q;
    addr_err_d = addr_err_q;
    if (do_load) begin
      pc_d       = load_tgt;
      addr_err_d = |load_tgt[1:0];
    end else if (do_seq) begin
      pc_d       = seq_pc;
      addr_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) addr_err_q <= 1'b0;
    else     addr_err_q <= addr_err_d;
  end

  assign addr_err_o = addr_err_q;
`else
  always_comb begin
    pc_d = pc_q;
    if (do_load)     pc_d = load_tgt & ~ADDR_W'(3);
    else if (do_seq) pc_d = seq_pc;
  end

  assign addr_err_o = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pc_q       <= RESET_PC;
      pc_valid_q <= 1'b0;
      pend_idx_q <= '0;
      pend_tgt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= 1'b1;
      pend_idx_q <= pend_idx_d;
      pend_tgt_q <= pend_tgt_d;
    end
  end

  if (FETCH_N == 1) begin : g_mask_single
    assign fetch_mask_o = 1'b1;
  end else begin : g_mask_multi
    logic [OFF_W-1:0] slot;
    assign slot = pc_q[OFF_W+1:2];
    always_comb begin
      for (int i = 0; i < FETCH_N; i++) begin
        fetch_mask_o[i] = (OFF_W'(i) >= slot);
      end
    end
  end

  assign pc_o            = pc_q;
  assign pc_valid_o      = pc_valid_q;
  assign redir_pending_o = (state_q == PEND);

endmodule

// File: tb/tb_preif_pc_gen.sv
// Bench for preif_pc_gen: directed vector table, hand sequences, random vs reference model.
module tb_preif_pc_gen;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned FETCH_N   = 2;
  localparam int unsigned NUM_REDIR = 3;
  localparam logic [31:0] RST_PC    = 32'hBFC0_0000;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        stall_i;
  logic [NUM_REDIR-1:0]        redir_valid_i;
  logic [NUM_REDIR*ADDR_W-1:0] redir_target_i;
  logic [ADDR_W-1:0]           pc_o;
  logic                        pc_valid_o;
  logic [FETCH_N-1:0]          fetch_mask_o;
  logic                        redir_pending_o;
  logic                        addr_err_o;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_valid, m_pend, m_err;
  int          m_pidx;
  logic [31:0] m_ptgt;

  always #5 clk = ~clk;

  preif_pc_gen #(
    .ADDR_W   (ADDR_W),
    .FETCH_N  (FETCH_N),
    .NUM_REDIR(NUM_REDIR),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .stall_i        (stall_i),
    .redir_valid_i  (redir_valid_i),
    .redir_target_i (redir_target_i),
    .pc_o           (pc_o),
    .pc_valid_o     (pc_valid_o),
    .fetch_mask_o   (fetch_mask_o),
    .redir_pending_o(redir_pending_o),
    .addr_err_o     (addr_err_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] tgt_of(input int i);
    return redir_target_i[i*32 +: 32];
  endfunction

  task automatic model_load(input logic [31:0] x);
`ifdef PC_ALIGN_CHECK_EN
    m_pc  = x;
    m_err = (x % 4) != 0;
`else
    m_pc  = x - (x % 4);
    m_err = 1'b0;
`endif
  endtask

  task automatic model_step();
    int w;
    logic [32:0] nxt;
    if (rst) begin
      m_pc = RST_PC; m_valid = 0; m_pend = 0; m_err = 0; m_pidx = 0; m_ptgt = 0;
      return;
    end
    m_valid = 1;
    w = -1;
    for (int i = NUM_REDIR - 1; i >= 0; i--) if (redir_valid_i[i]) w = i;
    if (!m_pend) begin
      if (!stall_i) begin
        if (w >= 0) model_load(tgt_of(w));
        else begin
          nxt   = 33'(m_pc - (m_pc % (4 * FETCH_N))) + 33'(4 * FETCH_N);
          m_pc  = nxt[31:0];
          m_err = 0;
        end
      end else if (w >= 0) begin
        m_pend = 1; m_pidx = w; m_ptgt = tgt_of(w);
      end
    end else begin
      if (stall_i) begin
        if (w >= 0 && w <= m_pidx) begin m_pidx = w; m_ptgt = tgt_of(w); end
      end else begin
        if (w >= 0 && w <= m_pidx) model_load(tgt_of(w));
        else model_load(m_ptgt);
        m_pend = 0;
      end
    end
  endtask

  function automatic logic [FETCH_N-1:0] model_mask(input logic [31:0] pc);
    logic [FETCH_N-1:0] m;
    int slot;
    slot = int'((pc >> 2) % FETCH_N);
    for (int i = 0; i < FETCH_N; i++) m[i] = (i >= slot);
    return m;
  endfunction

  task automatic step(input logic r, input logic s, input logic [2:0] v,
                      input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
    @(negedge clk);
    rst = r; stall_i = s; redir_valid_i = v;
    redir_target_i = {a2, a1, a0};
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"},    64'(pc_o),            64'(m_pc));
    check({tag, ".valid"}, 64'(pc_valid_o),      64'(m_valid));
    check({tag, ".mask"},  64'(fetch_mask_o),    64'(model_mask(m_pc)));
    check({tag, ".pend"},  64'(redir_pending_o), 64'(m_pend));
    check({tag, ".err"},   64'(addr_err_o),      64'(m_err));
  endtask

  typedef struct {
    logic        stall;
    logic [2:0]  v;
    logic [31:0] t0, t1, t2;
    logic [31:0] pc;
    logic [1:0]  mask;
    logic        pend;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [2:0] v, input logic [31:0] t0,
                              input logic [31:0] t1, input logic [31:0] t2, input logic [31:0] pc,
                              input logic [1:0] mask, input logic pend, input logic err);
    vec_t x;
    x.stall = s; x.v = v; x.t0 = t0; x.t1 = t1; x.t2 = t2;
    x.pc = pc; x.mask = mask; x.pend = pend; x.err = err;
    return x;
  endfunction

  vec_t tbl[16];

  initial begin
    rst = 1; stall_i = 0; redir_valid_i = '0; redir_target_i = '0;

    tbl[0]  = mk(0, 3'b000, 0, 0, 0, 32'hBFC0_0008, 2'b11, 0, 0);
    tbl[1]  = mk(0, 3'b000, 0, 0, 0, 32'hBFC0_0010, 2'b11, 0, 0);
    tbl[2]  = mk(0, 3'b000, 0, 0, 0, 32'hBFC0_0018, 2'b11, 0, 0);
    tbl[3]  = mk(0, 3'b110, 0, 32'h8000_0004, 32'h8000_1000, 32'h8000_0004, 2'b10, 0, 0);
    tbl[4]  = mk(0, 3'b000, 0, 0, 0, 32'h8000_0008, 2'b11, 0, 0);
    tbl[5]  = mk(1, 3'b100, 0, 0, 32'h0000_0100, 32'h8000_0008, 2'b11, 1, 0);
    tbl[6]  = mk(1, 3'b001, 32'hBFC0_0380, 0, 0, 32'h8000_0008, 2'b11, 1, 0);
    tbl[7]  = mk(1, 3'b000, 0, 0, 0, 32'h8000_0008, 2'b11, 1, 0);
    tbl[8]  = mk(1, 3'b000, 0, 0, 0, 32'h8000_0008, 2'b11, 1, 0);
    tbl[9]  = mk(1, 3'b000, 0, 0, 0, 32'h8000_0008, 2'b11, 1, 0);
    tbl[10] = mk(0, 3'b000, 0, 0, 0, 32'hBFC0_0380, 2'b11, 0, 0);
    tbl[11] = mk(1, 3'b001, 32'hBFC0_0384, 0, 0, 32'hBFC0_0380, 2'b11, 1, 0);
    tbl[12] = mk(0, 3'b100, 0, 0, 32'h0000_0100, 32'hBFC0_0384, 2'b10, 0, 0);
`ifdef PC_ALIGN_CHECK_EN
    tbl[13] = mk(0, 3'b010, 0, 32'h8000_0006, 0, 32'h8000_0006, 2'b10, 0, 1);
`else
    tbl[13] = mk(0, 3'b010, 0, 32'h8000_0006, 0, 32'h8000_0004, 2'b10, 0, 0);
`endif
    tbl[14] = mk(0, 3'b000, 0, 0, 0, 32'h8000_0008, 2'b11, 0, 0);
    tbl[15] = mk(1, 3'b100, 0, 0, 32'h0000_0200, 32'h8000_0008, 2'b11, 1, 0);

    // Reset state
    step(1, 0, 3'b000, 0, 0, 0);
    step(1, 0, 3'b000, 0, 0, 0);
    check("rst.pc",    64'(pc_o),            64'(RST_PC));
    check("rst.valid", 64'(pc_valid_o),      64'(0));
    check("rst.mask",  64'(fetch_mask_o),    64'(2'b11));
    check("rst.pend",  64'(redir_pending_o), 64'(0));
    check("rst.err",   64'(addr_err_o),      64'(0));

    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].stall, tbl[i].v, tbl[i].t0, tbl[i].t1, tbl[i].t2);
      check($sformatf("vec%0d.pc", i),   64'(pc_o),            64'(tbl[i].pc));
      check($sformatf("vec%0d.mask", i), 64'(fetch_mask_o),    64'(tbl[i].mask));
      check($sformatf("vec%0d.pend", i), 64'(redir_pending_o), 64'(tbl[i].pend));
      check($sformatf("vec%0d.err", i),  64'(addr_err_o),      64'(tbl[i].err));
      check($sformatf("vec%0d.valid", i), 64'(pc_valid_o),     64'(1));
    end

    // Reset mid-stall with a buffered redirect discards it
    step(1, 1, 3'b001, 32'h1234_5678, 0, 0);
    check("rst_stall.pc",    64'(pc_o),            64'(RST_PC));
    check("rst_stall.pend",  64'(redir_pending_o), 64'(0));
    check("rst_stall.valid", 64'(pc_valid_o),      64'(0));
    step(0, 0, 3'b000, 0, 0, 0);
    check("post_rst.pc",    64'(pc_o),       64'(32'hBFC0_0008));
    check("post_rst.valid", 64'(pc_valid_o), 64'(1));

    // Pending idx 0 survives release against a lower-priority request
    step(0, 1, 3'b001, 32'h9000_0010, 0, 0);
    step(0, 0, 3'b100, 0, 0, 32'h0000_0040);
    check("pend0_rel.pc",   64'(pc_o),            64'(32'h9000_0010));
    check("pend0_rel.pend", 64'(redir_pending_o), 64'(0));

    // Sequential wrap from the top block to zero
    step(0, 0, 3'b001, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 3'b000, 0, 0, 0);
    check("wrap.pc",   64'(pc_o),         64'(0));
    check("wrap.mask", 64'(fetch_mask_o), 64'(2'b11));

    // Random traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0),
           3'($urandom_range(0, 7) & ($urandom_range(0, 1) ? 3'b111 : 3'b000)),
           $urandom, $urandom, $urandom);
      check_model($sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
